muxn_rr_reg: RTL
================

Name: muxn_rr_reg

Overview:
- Registered N-channel, WIDTH-bit multiplexer; generalises the 2:1 combinational mux (`select`/`in0`/`in1`/`out`).
- Adds a per-channel valid/ready handshake, a one-entry output register, and two selection modes: direct (external `select`) and round-robin arbitration over requesting channels.
- Sits between N producer streams and a single consumer, e.g. sharing one bus or FIFO write port.

Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (2..16).
- SELW, $clog2(N), select/index width; derived localparam, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- select  input  SELW  channel index used in direct mode.
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept; combinational.
- out  output  WIDTH  registered data.
- out_valid  output  1  out holds an unconsumed word.
- out_ready  input  1  consumer accept.
- out_sel  output  SELW  index of the channel that supplied `out`.

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, out_sel=0, rr pointer ptr=0; in_ready=0 while rst_n=0.
- Load condition: can_load = !out_valid || out_ready.
- Grant, direct mode: g = select if select < N and in_valid[select]; otherwise no grant (select >= N is ignored, no X propagation).
- Grant, rr mode: g = first k with in_valid[k], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap-around); no grant if in_valid == 0.
- in_ready[k] = can_load && grant_valid && (g == k); at most one bit set; purely combinational from mode/select/in_valid/ptr/out_valid/out_ready.
- Transfer on channel k occurs when in_valid[k] && in_ready[k]. Next edge: out <= in_data[k], out_sel <= k, out_valid <= 1. Latency is 1 cycle input to out.
- If out_valid && out_ready && no grant: out_valid <= 0. out and out_sel hold their last values.
- If out_valid && !out_ready: out, out_sel and out_valid are held; all in_ready=0 (backpressure).
- Simultaneous drain and load (out_ready=1, grant present): new word loaded the same edge; full throughput of one word per cycle.
- ptr updates only on an rr-mode transfer: ptr <= (g == N-1) ? 0 : g+1. ptr is unchanged in direct mode and on cycles without a transfer.
- Mode or select change: takes effect on the next grant computation. A word already in the output register is unaffected.
- rst_n asserted mid-transfer: the word is dropped, outputs return to reset values immediately, ptr=0.
- No combinational path from in_data to out.

Decomposition:
- Package muxn_pkg: MODE_DIRECT=1'b0 and MODE_RR=1'b1 constants, default WIDTH/N.
- Sub-module rr_arbiter: parametrised N-bit rotating-priority arbiter. Inputs: req, ptr. Outputs: grant_valid, grant index. Reused by later blocks.
- Top muxn_rr_reg contains direct-mode select logic, handshake, output register and ptr.

Test Plan:
- Reset: rst_n=0 with all in_valid=1 -> out=0, out_valid=0, out_sel=0, in_ready=0; after release, first rr grant is ch0.
- Direct mode, N=4, WIDTH=8: select=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next edge out=8'hA5, out_sel=2. Then select=3 with in_valid[3]=0 -> no grant; out_valid falls the following edge.
- Round-robin fairness: in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3, one word per cycle. Then in_valid=4'b1010 -> sequence 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> out/out_sel stable, in_ready=0, ptr unchanged. out_ready=1 -> next grant taken the same cycle, no word lost or duplicated.
- Wrap and edge cases: ptr=3, in_valid=4'b1001 -> grant ch3 then ch0. select=3'd5 with N=5? no: N=4, SELW=2 with no out-of-range value possible -> also run N=3, select=2'd3 -> no grant, out holds.
- Async reset mid-stream: assert rst_n between edges while out_valid=1 -> out_valid=0 and out=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared constants for the registered N-channel mux family.
package muxn_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_N     = 4;

endpackage : muxn_pkg

// File: rtl/muxn_rr_reg_rr_arbiter.sv
// Rotating-priority arbiter: searches req from ptr upward, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant
);

  int unsigned idx;

  // First requester at or after ptr in circular order wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (i + {{(32-PW){1'b0}}, ptr}) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx[PW-1:0];
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/muxn_rr_reg.sv
// Registered N:1 mux with valid/ready per channel, direct or round-robin selection.
module muxn_rr_reg
  import muxn_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    select,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_sel
);

  logic [SELW-1:0]  ptr;
  logic             rr_gv;
  logic [SELW-1:0]  rr_g;
  logic             dir_gv;
  logic             gv;
  logic [SELW-1:0]  g;
  logic             can_load;
  logic [WIDTH-1:0] load_data;

  rr_arbiter #(
    .N  (N),
    .PW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant_valid (rr_gv),
    .grant       (rr_g)
  );

  // Direct grant; an out-of-range select matches no channel, so it never grants.
  always_comb begin
    dir_gv = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (SELW'(k) == select && in_valid[k]) dir_gv = 1'b1;
    end
  end

  // Grant mux, load condition and one-hot ready.
  always_comb begin
    gv       = (mode == MODE_RR) ? rr_gv : dir_gv;
    g        = (mode == MODE_RR) ? rr_g  : select;
    can_load = !out_valid || out_ready;
    in_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      in_ready[k] = rst_n && can_load && gv && (SELW'(k) == g);
    end
  end

  // Data of the granted channel.
  always_comb begin
    load_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (SELW'(k) == g) load_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (can_load) begin
      if (gv) begin
        out       <= load_data;
        out_sel   <= g;
        out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          if ({{(32-SELW){1'b0}}, g} == N - 1) ptr <= '0;
          else                                 ptr <= g + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule : muxn_rr_reg
